// File: rtl/rv32i_sequencer.sv
// rv32i_sequencer: multicycle fetch/decode/execute/memoryaccess/writeback stage controller
// with strobe/acknowledge memory handshakes. Bus watchdog built when RV32I_BUS_TIMEOUT_EN is defined.
module rv32i_sequencer #(
  parameter logic [31:0] PC_RESET       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc,
  output logic [31:0] o_iaddr,
  output logic        o_istb,
  input  logic        i_iack,
  input  logic [31:0] i_inst,
  output logic [31:0] o_inst_q,
  input  logic        i_mem_op,
  output logic        o_dstb,
  input  logic        i_dack,
  input  logic        i_stall,
  output logic [2:0]  o_stage_q,
  output logic        o_alu_stage,
  output logic        o_memoryaccess_stage,
  output logic        o_writeback_stage,
  output logic        o_csr_stage,
  output logic        o_done_tick,
  output logic        o_ibus_err,
  output logic        o_dbus_err
);

  // state          | meaning
  // S_FETCH        | request instruction at o_iaddr, hold while stalled
  // S_DECODE       | one cycle for the decoder to digest o_inst_q
  // S_EXECUTE      | ALU enable for one cycle
  // S_MEMORYACCESS | CSR on first cycle; data request until ack for load/store
  // S_WRITEBACK    | retire, latch next PC
  localparam logic [2:0] S_FETCH        = 3'd0;
  localparam logic [2:0] S_DECODE       = 3'd1;
  localparam logic [2:0] S_EXECUTE      = 3'd2;
  localparam logic [2:0] S_MEMORYACCESS = 3'd3;
  localparam logic [2:0] S_WRITEBACK    = 3'd4;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("rv32i_sequencer: TIMEOUT_CYCLES must be within 2..65536");
  end

  logic [2:0]  stage_q, stage_n;
  logic        ireq_q, dreq_q;
  logic [31:0] inst_q, pc_q;
  logic        istb, dstb;
  logic        iexpire, dexpire;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) stage_q <= S_FETCH;
    else          stage_q <= stage_n;
  end

  always_comb begin
    stage_n = stage_q;
    case (stage_q)
      S_FETCH:        if ((istb && i_iack) || iexpire) stage_n = S_DECODE;
      S_DECODE:       stage_n = S_EXECUTE;
      S_EXECUTE:      stage_n = S_MEMORYACCESS;
      S_MEMORYACCESS: if (!dstb || i_dack || dexpire) stage_n = S_WRITEBACK;
      S_WRITEBACK:    stage_n = S_FETCH;
      default:        stage_n = S_FETCH;
    endcase
  end

  // A raised request flag keeps the strobe up regardless of i_stall; the first
  // MEMORYACCESS cycle is the one with no data request outstanding yet.
  always_comb begin
    istb                 = 1'b0;
    dstb                 = 1'b0;
    o_alu_stage          = 1'b0;
    o_memoryaccess_stage = 1'b0;
    o_csr_stage          = 1'b0;
    o_writeback_stage    = 1'b0;
    o_done_tick          = 1'b0;
    case (stage_q)
      S_FETCH:        istb = i_rst_n && (ireq_q || !i_stall);
      S_EXECUTE:      o_alu_stage = 1'b1;
      S_MEMORYACCESS: begin
        o_memoryaccess_stage = 1'b1;
        o_csr_stage          = !dreq_q;
        dstb                 = dreq_q || i_mem_op;
      end
      S_WRITEBACK: begin
        o_writeback_stage = 1'b1;
        o_done_tick       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ireq_q <= 1'b0;
      dreq_q <= 1'b0;
      inst_q <= '0;
      pc_q   <= PC_RESET;
    end else begin
      ireq_q <= istb && !i_iack && !iexpire;
      dreq_q <= dstb && !i_dack && !dexpire;
      if (istb && i_iack) inst_q <= i_inst;
      else if (iexpire)   inst_q <= '0;
      if (stage_q == S_WRITEBACK) pc_q <= i_pc;
    end
  end

`ifdef RV32I_BUS_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmr_q, tmr_rem;
  logic          ibus_err_q, dbus_err_q;

  // Down-counter holds remaining wait cycles; a fresh request starts from T_LOAD.
  always_comb begin
    tmr_rem = (ireq_q || dreq_q) ? tmr_q : T_LOAD;
    iexpire = istb && !i_iack && (tmr_rem == '0);
    dexpire = dstb && !i_dack && (tmr_rem == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmr_q      <= '0;
      ibus_err_q <= 1'b0;
      dbus_err_q <= 1'b0;
    end else begin
      if (((istb && !i_iack) || (dstb && !i_dack)) && !iexpire && !dexpire)
        tmr_q <= tmr_rem - TW'(1);
      else
        tmr_q <= '0;
      ibus_err_q <= iexpire;
      dbus_err_q <= dexpire;
    end
  end

  assign o_ibus_err = ibus_err_q;
  assign o_dbus_err = dbus_err_q;
`else
  assign iexpire    = 1'b0;
  assign dexpire    = 1'b0;
  assign o_ibus_err = 1'b0;
  assign o_dbus_err = 1'b0;
`endif

  assign o_stage_q = stage_q;
  assign o_iaddr   = pc_q;
  assign o_inst_q  = inst_q;
  assign o_istb    = istb;
  assign o_dstb    = dstb;

endmodule
